group_add_stream: RTL and testbench

- Pipelined, flow-controlled signed adder tree. Sums GROUP_NB lanes per beat.
- Optional mode accumulates the per-beat sums across a packet delimited by up_last.
- Sits between the convolution multiplier array and the output/requantise stage.
- Successor to the free-running fixed-latency group adder. Adds a valid/ready handshake, reset, separate input/internal/output widths and packet accumulation.

---
 rtl/group_add_pkg.sv | 52 +++++
 rtl/group_add_level.sv | 45 ++++
 rtl/group_add_stream.sv | 147 ++++++++++++++
 tb/tb_group_add_stream.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/group_add_pkg.sv
// Shared helpers for the streaming group adder: tree sizing, sign extension
// and output formatting. Build macro: GROUP_ADD_SAT_EN selects saturating
// output formatting instead of plain truncation.
package group_add_pkg;

  // Number of registered tree levels needed to reduce n lanes to one: clog2(n).
  function automatic int tree_levels(input int n);
    int l;
    l = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) l = i + 1;
    end
    return l;
  endfunction

  // Cycles from the accepting edge to dn_valid: input reg + L levels + output reg.
  function automatic int latency(input int n);
    return tree_levels(n) + 2;
  endfunction

  // Node count after k tree levels (pairs summed, odd top element passes).
  function automatic int level_count(input int n, input int k);
    int c;
    c = n;
    for (int i = 0; i < 31; i++) begin
      if (i < k) c = (c + 1) / 2;
    end
    return c;
  endfunction

  // Sign-extend the low w bits of x to 64 bits; callers keep the width they need.
  function automatic logic signed [63:0] sext_acc(input logic [63:0] x, input int w);
    return $signed(x << (64 - w)) >>> (64 - w);
  endfunction

  // Output formatting of a sign-extended accumulator value to out_w bits.
  function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] x, input int out_w);
`ifdef GROUP_ADD_SAT_EN
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
`else
    // Truncation: the caller keeps only the low out_w bits.
    return x;
`endif
  endfunction

endpackage

// File: rtl/group_add_level.sv
// One registered level of the adder tree: adjacent pairs are summed, an odd
// top element passes through unchanged. valid/last travel with the data and
// everything holds while en is low.
module group_add_level #(
  parameter int IN_NB     = 2,
  parameter int ACC_WIDTH = 24,
  localparam int OUT_NB   = (IN_NB + 1) / 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [IN_NB*ACC_WIDTH-1:0]  in_data,
  input  logic                        in_valid,
  input  logic                        in_last,
  output logic [OUT_NB*ACC_WIDTH-1:0] out_data,
  output logic                        out_valid,
  output logic                        out_last
);

  logic [OUT_NB*ACC_WIDTH-1:0] sum_d;

  // Combinational pair sums for this level (wrapping ACC_WIDTH adds).
  for (genvar j = 0; j < OUT_NB; j++) begin : g_node
    if ((2 * j + 1) < IN_NB) begin : g_pair
      assign sum_d[j*ACC_WIDTH +: ACC_WIDTH] = in_data[(2*j)*ACC_WIDTH +: ACC_WIDTH]
                                             + in_data[(2*j+1)*ACC_WIDTH +: ACC_WIDTH];
    end else begin : g_pass
      assign sum_d[j*ACC_WIDTH +: ACC_WIDTH] = in_data[(2*j)*ACC_WIDTH +: ACC_WIDTH];
    end
  end

  // Level register; advances only when the global stall is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (en) begin
      out_data  <= sum_d;
      out_valid <= in_valid;
      out_last  <= in_last;
    end
  end

endmodule

// File: rtl/group_add_stream.sv
// Pipelined, flow-controlled signed adder tree summing GROUP_NB lanes per beat,
// optionally accumulating beat sums over an up_last-delimited packet.
// Build macro: GROUP_ADD_SAT_EN saturates dn_data instead of truncating.
//
// Handshake: a beat moves on up_valid && up_ready, a result on
// dn_valid && dn_ready. The whole pipeline shares one stall, en = !dn_valid || dn_ready,
// and up_ready = en, so dn_data/dn_valid are stable while dn_valid && !dn_ready.
module group_add_stream
  import group_add_pkg::*;
#(
  parameter int GROUP_NB  = 4,
  parameter int NUM_WIDTH = 16,
  parameter int ACC_WIDTH = 24,
  parameter int OUT_WIDTH = 16,
  parameter int ACC_MODE  = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_WIDTH*GROUP_NB-1:0] up_data,
  input  logic                          up_last,
  input  logic                          up_valid,
  output logic                          up_ready,
  output logic [OUT_WIDTH-1:0]          dn_data,
  output logic                          dn_valid,
  input  logic                          dn_ready
);

  localparam int L = tree_levels(GROUP_NB);
  localparam int W = ACC_WIDTH;

  logic en;
  assign en       = !dn_valid || dn_ready;
  assign up_ready = en;

  // Per-stage data, valid and last; index 0 is the input register, L the tree root.
  logic [GROUP_NB*W-1:0] lvl_data  [0:L];
  logic                  lvl_valid [0:L];
  logic                  lvl_last  [0:L];

  // Lanes sign-extended to ACC_WIDTH on entry.
  logic [GROUP_NB*W-1:0] in_ext;
  for (genvar i = 0; i < GROUP_NB; i++) begin : g_lane
    logic [63:0] ext;
    assign ext = sext_acc(64'(up_data[i*NUM_WIDTH +: NUM_WIDTH]), NUM_WIDTH);
    assign in_ext[i*W +: W] = ext[W-1:0];
  end

  logic [GROUP_NB*W-1:0] s0_data;
  logic                  s0_valid;
  logic                  s0_last;

  // Stage 0: input register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_data  <= '0;
      s0_valid <= 1'b0;
      s0_last  <= 1'b0;
    end else if (en) begin
      s0_data  <= in_ext;
      s0_valid <= up_valid;
      s0_last  <= up_last;
    end
  end

  assign lvl_data[0]  = s0_data;
  assign lvl_valid[0] = s0_valid;
  assign lvl_last[0]  = s0_last;

  // Stages 1..L: one registered tree level each.
  for (genvar k = 1; k <= L; k++) begin : g_level
    localparam int IN_NB  = level_count(GROUP_NB, k - 1);
    localparam int OUT_NB = level_count(GROUP_NB, k);
    logic [OUT_NB*W-1:0] out_d;
    logic                out_v;
    logic                out_l;

    group_add_level #(
      .IN_NB     (IN_NB),
      .ACC_WIDTH (W)
    ) u_level (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .in_data   (lvl_data[k-1][IN_NB*W-1:0]),
      .in_valid  (lvl_valid[k-1]),
      .in_last   (lvl_last[k-1]),
      .out_data  (out_d),
      .out_valid (out_v),
      .out_last  (out_l)
    );

    if (OUT_NB < GROUP_NB) begin : g_pad
      assign lvl_data[k] = {{((GROUP_NB - OUT_NB) * W){1'b0}}, out_d};
    end else begin : g_full
      assign lvl_data[k] = out_d;
    end
    assign lvl_valid[k] = out_v;
    assign lvl_last[k]  = out_l;
  end

  logic [W-1:0] sum;
  logic         top_valid;
  logic         top_last;
  assign sum       = lvl_data[L][W-1:0];
  assign top_valid = lvl_valid[L];
  assign top_last  = lvl_last[L];

  logic [W-1:0] acc;
  logic         first;
  logic [W-1:0] acc_next;
  logic [W-1:0] result;
  logic [63:0]  fmt_full;

  // Packet running sum; the first beat of a packet ignores any stale acc value.
  always_comb begin
    acc_next = (first ? '0 : acc) + sum;
    result   = (ACC_MODE != 0) ? acc_next : sum;
    fmt_full = sat_trunc(sext_acc(64'(result), W), OUT_WIDTH);
  end

  // Stage L+1: accumulate and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dn_data  <= '0;
      dn_valid <= 1'b0;
      acc      <= '0;
      first    <= 1'b1;
    end else if (en) begin
      if (!top_valid) begin
        dn_valid <= 1'b0;
      end else if (ACC_MODE == 0) begin
        dn_data  <= fmt_full[OUT_WIDTH-1:0];
        dn_valid <= 1'b1;
      end else if (top_last) begin
        dn_data  <= fmt_full[OUT_WIDTH-1:0];
        dn_valid <= 1'b1;
        acc      <= '0;
        first    <= 1'b1;
      end else begin
        acc      <= acc_next;
        first    <= 1'b0;
        dn_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_group_add_stream.sv
// Directed bench for group_add_stream: three instances cover GROUP_NB=4 per-beat
// sums, GROUP_NB=5 (odd tree) and GROUP_NB=4 packet accumulation.
module tb_group_add_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // GROUP_NB=4, ACC_MODE=0
  logic [63:0] up_data0 = '0;
  logic        up_valid0 = 1'b0;
  logic        up_ready0;
  logic [15:0] dn_data0;
  logic        dn_valid0;
  logic        dn_ready0 = 1'b1;

  // GROUP_NB=5, ACC_MODE=0
  logic [79:0] up_data5 = '0;
  logic        up_valid5 = 1'b0;
  logic        up_ready5;
  logic [15:0] dn_data5;
  logic        dn_valid5;
  logic        dn_ready5 = 1'b1;

  // GROUP_NB=4, ACC_MODE=1
  logic [63:0] up_data_a = '0;
  logic        up_last_a = 1'b0;
  logic        up_valid_a = 1'b0;
  logic        up_ready_a;
  logic [15:0] dn_data_a;
  logic        dn_valid_a;
  logic        dn_ready_a = 1'b1;

`ifdef GROUP_ADD_SAT_EN
  localparam logic [15:0] ACC_BIG_EXP = 16'h7FFF;
`else
  localparam logic [15:0] ACC_BIG_EXP = 16'hEA60;
`endif

  int n_pass  = 0;
  int n_total = 0;

  group_add_stream #(.GROUP_NB(4), .NUM_WIDTH(16), .ACC_WIDTH(24), .OUT_WIDTH(16), .ACC_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .up_data(up_data0), .up_last(1'b0), .up_valid(up_valid0),
    .up_ready(up_ready0), .dn_data(dn_data0), .dn_valid(dn_valid0), .dn_ready(dn_ready0)
  );

  group_add_stream #(.GROUP_NB(5), .NUM_WIDTH(16), .ACC_WIDTH(24), .OUT_WIDTH(16), .ACC_MODE(0)) dut5 (
    .clk(clk), .rst(rst), .up_data(up_data5), .up_last(1'b0), .up_valid(up_valid5),
    .up_ready(up_ready5), .dn_data(dn_data5), .dn_valid(dn_valid5), .dn_ready(dn_ready5)
  );

  group_add_stream #(.GROUP_NB(4), .NUM_WIDTH(16), .ACC_WIDTH(24), .OUT_WIDTH(16), .ACC_MODE(1)) dut_a (
    .clk(clk), .rst(rst), .up_data(up_data_a), .up_last(up_last_a), .up_valid(up_valid_a),
    .up_ready(up_ready_a), .dn_data(dn_data_a), .dn_valid(dn_valid_a), .dn_ready(dn_ready_a)
  );

  function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_total++; if (dn_valid0 !== 1'b0) $display("FAIL reset_dn_valid: got %b want 0", dn_valid0); else n_pass++;
    n_total++; if (dn_data0 !== 16'h0000) $display("FAIL reset_dn_data: got %h want 0000", dn_data0); else n_pass++;
    n_total++; if (up_ready0 !== 1'b1) $display("FAIL reset_up_ready: got %b want 1", up_ready0); else n_pass++;
    n_total++; if (dn_valid_a !== 1'b0) $display("FAIL reset_acc_dn_valid: got %b want 0", dn_valid_a); else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_sum();
    up_valid0 = 1'b1;
    up_data0  = pack4(1, 2, 3, 4);
    tick();                                   // edge 1: accepted
    up_data0  = pack4(-1, -1, -1, -1);
    tick();                                   // edge 2
    up_valid0 = 1'b0;
    tick();                                   // edge 3
    n_total++; if (dn_valid0 !== 1'b0) $display("FAIL basic_not_early: got %b want 0", dn_valid0); else n_pass++;
    tick();                                   // edge 4
    n_total++; if (dn_valid0 !== 1'b1) $display("FAIL basic_valid_10: got %b want 1", dn_valid0); else n_pass++;
    n_total++; if (dn_data0 !== 16'd10) $display("FAIL basic_sum_10: got %h want 000a", dn_data0); else n_pass++;
    tick();
    n_total++; if (dn_valid0 !== 1'b1) $display("FAIL basic_valid_neg: got %b want 1", dn_valid0); else n_pass++;
    n_total++; if (dn_data0 !== 16'hFFFC) $display("FAIL basic_sum_neg4: got %h want fffc", dn_data0); else n_pass++;
    tick();
    n_total++; if (dn_valid0 !== 1'b0) $display("FAIL basic_drain: got %b want 0", dn_valid0); else n_pass++;
  endtask

  task automatic test_odd_group();
    up_valid5 = 1'b1;
    up_data5  = {16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    tick();                                   // edge 1: accepted
    up_valid5 = 1'b0;
    repeat (3) tick();                        // edge 4
    n_total++; if (dn_valid5 !== 1'b0) $display("FAIL odd_not_early: got %b want 0", dn_valid5); else n_pass++;
    tick();                                   // edge 5
    n_total++; if (dn_valid5 !== 1'b1) $display("FAIL odd_valid: got %b want 1", dn_valid5); else n_pass++;
    n_total++; if (dn_data5 !== 16'd15) $display("FAIL odd_sum_15: got %h want 000f", dn_data5); else n_pass++;
    tick();
  endtask

  task automatic test_reset_midstream();
    int stale;
    stale = 0;
    for (int i = 0; i < 3; i++) begin
      up_valid0 = 1'b1;
      up_data0  = pack4(1, 2, 3, 4);
      tick();
    end
    up_valid0 = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_total++; if (dn_valid0 !== 1'b0) $display("FAIL mid_rst_dn_valid: got %b want 0", dn_valid0); else n_pass++;
    n_total++; if (dn_data0 !== 16'h0000) $display("FAIL mid_rst_dn_data: got %h want 0000", dn_data0); else n_pass++;
    tick();
    rst = 1'b0;
    tick();
    n_total++; if (up_ready0 !== 1'b1) $display("FAIL mid_rst_up_ready: got %b want 1", up_ready0); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      if (dn_valid0 !== 1'b0) stale++;
      tick();
    end
    n_total++; if (stale !== 0) $display("FAIL mid_rst_stale: got %0d outputs want 0", stale); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_v [4];
    logic [15:0] held;
    logic [15:0] out_val;
    bit          held_ok;
    bit          acc_hs;
    bit          out_hs;
    int          sent;
    int          recv;
    int          stall_cycles;
    int          extra;
    exp_v = '{16'd10, 16'd20, 16'd30, 16'd40};
    held = '0;
    held_ok = 1'b0;
    sent = 0;
    recv = 0;
    stall_cycles = 0;
    extra = 0;
    for (int c = 0; c < 60 && recv < 4; c++) begin
      dn_ready0 = !(c >= 4 && c < 10);
      up_valid0 = (sent < 4);
      up_data0  = pack4(sent + 1, 2 * (sent + 1), 3 * (sent + 1), 4 * (sent + 1));
      #1;
      acc_hs  = up_valid0 && up_ready0;
      out_hs  = dn_valid0 && dn_ready0;
      out_val = dn_data0;
      if (!dn_ready0 && dn_valid0) begin
        stall_cycles++;
        n_total++; if (up_ready0 !== 1'b0) $display("FAIL bp_up_ready c=%0d: got %b want 0", c, up_ready0); else n_pass++;
        if (held_ok) begin
          n_total++; if (dn_data0 !== held) $display("FAIL bp_hold c=%0d: got %h want %h", c, dn_data0, held); else n_pass++;
        end
        held = dn_data0;
        held_ok = 1'b1;
      end else begin
        held_ok = 1'b0;
      end
      tick();
      if (acc_hs) sent++;
      if (out_hs) begin
        n_total++; if (out_val !== exp_v[recv]) $display("FAIL bp_order[%0d]: got %h want %h", recv, out_val, exp_v[recv]); else n_pass++;
        recv++;
      end
    end
    n_total++; if (recv !== 4) $display("FAIL bp_count: got %0d outputs want 4", recv); else n_pass++;
    n_total++; if (stall_cycles !== 6) $display("FAIL bp_stall_cycles: got %0d want 6", stall_cycles); else n_pass++;
    up_valid0 = 1'b0;
    dn_ready0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (dn_valid0 === 1'b1) extra++;
      tick();
    end
    n_total++; if (extra !== 0) $display("FAIL bp_duplicate: got %0d extra outputs want 0", extra); else n_pass++;
  endtask

  task automatic test_acc_two_beats();
    up_valid_a = 1'b1;
    up_last_a  = 1'b0;
    up_data_a  = pack4(10000, 10000, 10000, 0);
    tick();                                   // edge 1
    up_last_a  = 1'b1;
    tick();                                   // edge 2
    up_valid_a = 1'b0;
    up_last_a  = 1'b0;
    tick();                                   // edge 3
    tick();                                   // edge 4: first beat at accumulator
    n_total++; if (dn_valid_a !== 1'b0) $display("FAIL acc_mid_packet: got %b want 0", dn_valid_a); else n_pass++;
    tick();                                   // edge 5
    n_total++; if (dn_valid_a !== 1'b1) $display("FAIL acc_valid: got %b want 1", dn_valid_a); else n_pass++;
    n_total++; if (dn_data_a !== ACC_BIG_EXP) $display("FAIL acc_big_sum: got %h want %h", dn_data_a, ACC_BIG_EXP); else n_pass++;
    tick();
    n_total++; if (dn_valid_a !== 1'b0) $display("FAIL acc_single_output: got %b want 0", dn_valid_a); else n_pass++;
  endtask

  task automatic test_acc_packets();
    logic [63:0] pk_data [5];
    bit          pk_last [5];
    logic [15:0] exp_v   [3];
    int          n_out;
    pk_data = '{pack4(1, 1, 1, 1), pack4(1, 2, 3, 4), pack4(5, 5, 5, 5), pack4(2, 2, 2, 2), pack4(1, 0, 0, 0)};
    pk_last = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_v   = '{16'd4, 16'd30, 16'd9};
    n_out = 0;
    for (int c = 0; c < 14; c++) begin
      up_valid_a = (c < 5);
      up_data_a  = (c < 5) ? pk_data[c] : '0;
      up_last_a  = (c < 5) ? pk_last[c] : 1'b0;
      tick();
      if (dn_valid_a === 1'b1) begin
        if (n_out < 3) begin
          n_total++; if (dn_data_a !== exp_v[n_out]) $display("FAIL pkt_sum[%0d]: got %h want %h", n_out, dn_data_a, exp_v[n_out]); else n_pass++;
        end
        n_out++;
      end
    end
    n_total++; if (n_out !== 3) $display("FAIL pkt_count: got %0d outputs want 3", n_out); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic_sum();
    test_odd_group();
    test_reset_midstream();
    test_backpressure();
    test_acc_two_beats();
    test_acc_packets();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
